serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Brief    : Request/result handshake bundle for the bit-serial adder.
// Revision : 1.0  initial release
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial a+b+cin adder, one bit per clock, valid/ready framed.
// Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             busy,
  serial_add_ctrl_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic [W-1:0]       w_sum_shift;
  logic               r_carry;
  logic               r_cout;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_s;
  logic               w_c;
  logic               w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == c_LAST);

  // New sum bit enters at the MSB so the LSB-first result lands in place after W shifts.
  always_comb begin
    w_sum_shift        = r_sum >> 1;
    w_sum_shift[W-1]   = w_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.in_valid)  w_next_state = RUN;
        RUN:     if (w_last)        w_next_state = DONE;
        DONE:    if (bus.out_ready) w_next_state = IDLE;
        default:                    w_next_state = IDLE;
      endcase
    end
  end

  // Abort leaves the datapath untouched so sum/cout keep their last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (!clr) begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_shift;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (w_last) begin
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl (W=8 and W=1 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic clr1;
  logic busy;
  logic busy1;
  int   errors = 0;
  int   checks = 0;

  serial_add_ctrl_if #(.W(W)) bus ();
  serial_add_ctrl_if #(.W(1)) bus1 ();

  serial_add_ctrl #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .busy (busy),
    .bus  (bus)
  );

  serial_add_ctrl #(.W(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr1),
    .busy (busy1),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid; 40 means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin errors++; $display("FAIL reset_sum_cout: got %h/%b required 00/0", bus.sum, bus.cout); end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    start_op(8'h10, 8'h20, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_accept: busy got %b required 1", busy); end
    wait_valid(lat);
    checks++; if (bus.sum !== 8'h31 || bus.cout !== 1'b0) begin errors++; $display("FAIL first_op_result: got %h/%b required 31/0", bus.sum, bus.cout); end
    tick();
  endtask

  task automatic test_basic();
    int lat;
    bus.out_ready = 1'b1;
    start_op(8'h5A, 8'h33, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_flags: in_ready/busy got %b/%b required 0/1", bus.in_ready, busy); end
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
    checks++; if (bus.sum !== 8'h8D || bus.cout !== 1'b0) begin errors++; $display("FAIL basic_result: got %h/%b required 8D/0", bus.sum, bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: out_valid/in_ready/busy got %b/%b/%b required 0/1/0", bus.out_valid, bus.in_ready, busy); end
  endtask

  task automatic test_carry();
    int lat;
    bus.out_ready = 1'b1;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_valid(lat);
    checks++; if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin errors++; $display("FAIL carry_ff_01: got %h/%b required 00/1", bus.sum, bus.cout); end
    tick();
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_valid(lat);
    checks++; if (bus.sum !== 8'hFF || bus.cout !== 1'b1) begin errors++; $display("FAIL carry_ff_ff_1: got %h/%b required FF/1", bus.sum, bus.cout); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    start_op(8'h9C, 8'h47, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 8'hE4 || bus.cout !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid/sum/cout/in_ready got %b/%h/%b/%b required 1/E4/0/0", i, bus.out_valid, bus.sum, bus.cout, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL handoff_no_accept: out_valid/busy got %b/%b required 0/0", bus.out_valid, busy); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    bus.out_ready = 1'b1;
    start_op(8'h77, 8'h11, 1'b0);
    tick(); tick(); tick();
    clr       = 1'b1;
    bus.in_valid = 1'b1;
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: in_ready/busy/valid got %b/%b/%b required 1/0/0", bus.in_ready, busy, bus.out_valid); end
    checks++; if (bus.sum !== prev_sum || bus.cout !== prev_cout) begin errors++; $display("FAIL abort_hold: got %h/%b required %h/%b", bus.sum, bus.cout, prev_sum, prev_cout); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles required 0", seen); end
    start_op(8'h01, 8'h02, 1'b0);
    wait_valid(lat);
    checks++; if (bus.sum !== 8'h03 || bus.cout !== 1'b0 || lat !== 8) begin errors++; $display("FAIL after_abort: sum/cout/lat got %h/%b/%0d required 03/0/8", bus.sum, bus.cout, lat); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.out_ready = 1'b1;
    start_op(8'hC3, 8'h5A, 1'b1);
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy/busy/valid/sum/cout got %b/%b/%b/%h/%b required 1/0/0/00/0", bus.in_ready, busy, bus.out_valid, bus.sum, bus.cout);
    end
    @(negedge clk);
    rst = 1'b1;
    start_op(8'hC3, 8'h5A, 1'b1);
    wait_valid(lat);
    checks++; if (lat !== 8 || bus.sum !== 8'h1E || bus.cout !== 1'b1) begin errors++; $display("FAIL post_reset_op: lat/sum/cout got %0d/%h/%b required 8/1E/1", lat, bus.sum, bus.cout); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   expv;
    int           lat;
    int           stall;
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      expv = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      bus.out_ready = 1'b0;
      start_op(a, b, c);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        bus.in_valid = 1'($urandom);
        tick();
        lat++;
      end
      checks++; if (lat !== W) begin errors++; $display("FAIL rand_lat[%0d]: got %0d required %0d", n, lat, W); end
      checks++; if (bus.sum !== expv[W-1:0] || bus.cout !== expv[W]) begin errors++; $display("FAIL rand_result[%0d]: got %h/%b required %h/%b", n, bus.sum, bus.cout, expv[W-1:0], expv[W]); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'($urandom);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== expv[W-1:0] || bus.cout !== expv[W]) begin errors++; $display("FAIL rand_stall[%0d]: got %b/%h/%b required 1/%h/%b", n, bus.out_valid, bus.sum, bus.cout, expv[W-1:0], expv[W]); end
      end
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_handoff[%0d]: valid/busy got %b/%b required 0/0", n, bus.out_valid, busy); end
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_w1();
    logic [2:0] v;
    logic [1:0] e;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      e = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      bus1.in_valid = 1'b1;
      bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0];
      tick();
      bus1.in_valid = 1'b0;
      checks++; if (bus1.out_valid !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL w1_run[%0d]: valid/busy got %b/%b required 0/1", i, bus1.out_valid, busy1); end
      tick();
      checks++; if (bus1.out_valid !== 1'b1 || bus1.sum !== e[0] || bus1.cout !== e[1]) begin errors++; $display("FAIL w1_result[%0d]: valid/sum/cout got %b/%b/%b required 1/%b/%b", i, bus1.out_valid, bus1.sum, bus1.cout, e[0], e[1]); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    clr1 = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_w1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
